// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types and constants for the fetch bundle buffer
package fetch_pkg;

    localparam int XLEN      = 32;
    localparam int MAX_LANES = 4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0;

    // One fetch bundle; lanes beyond the configured WIDTH are held at zero.
    typedef struct packed {
        logic [MAX_LANES-1:0][XLEN-1:0] inst;
        logic [MAX_LANES-1:0]           pred;
        logic [MAX_LANES-1:0]           mask;
        logic [XLEN-1:0]                pc;
    } bundle_t;

endpackage

// File: rtl/fetch2_bundle_fifo.sv
// rtl/fetch2_bundle_fifo.sv - bundle storage with wrapping pointers and occupancy count
module fetch2_bundle_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    wr_en,
    input  bundle_t wr_data,
    input  logic    rd_en,
    output bundle_t rd_data,
    output logic [AW:0] count
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    bundle_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Payload storage needs no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_ONE;
            end else if (!wr_en && rd_en) begin
                count <= count - CNT_ONE;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch2_buf.sv
// rtl/fetch2_buf.sv - fetch-to-decode bundle queue with redirect flush shadow (optional FETCH2_BUF_BYPASS_EN)
module fetch2_buf
    import fetch_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int DEPTH        = 4,
    parameter int FLUSH_SHADOW = 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  fetch_valid_i,
    input  logic [XLEN*WIDTH-1:0] idata_i,
    input  logic [WIDTH-1:0]      lane_mask_i,
    input  logic [WIDTH-1:0]      pred_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  branch_mispred_i,
    input  logic                  wasnt_branch_i,
    input  logic                  decode_ready_i,
    output logic                  fetch_ready_o,
    output logic                  valid_o,
    output logic [XLEN*WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0]      pred_o,
    output logic [XLEN-1:0]       pc_o,
    output logic [CW-1:0]         count_o,
    output logic                  branch_flush_o
);

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [2:0]    SHADOW_INIT = 3'(FLUSH_SHADOW);

    logic       redirect;
    logic [2:0] shadow_cnt;
    logic       qualify;
    logic       stored_valid;
    logic       bypass;
    logic       wr_en;
    logic       rd_en;
    bundle_t    in_b;
    bundle_t    rd_b;
    bundle_t    head;

    assign redirect       = branch_mispred_i | wasnt_branch_i;
    assign branch_flush_o = redirect | (shadow_cnt != 3'd0);
    assign fetch_ready_o  = (count_o < DEPTH_C);
    assign stored_valid   = (count_o != '0);
    assign qualify        = fetch_valid_i & ~branch_flush_o & (lane_mask_i != '0);

    // Discard window after a redirect; only advances when the frontend delivers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shadow_cnt <= 3'd0;
        end else if (redirect) begin
            shadow_cnt <= SHADOW_INIT;
        end else if (fetch_valid_i && (shadow_cnt != 3'd0)) begin
            shadow_cnt <= shadow_cnt - 3'd1;
        end
    end

`ifdef FETCH2_BUF_BYPASS_EN
    assign bypass = qualify & ~stored_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed bundle consumed by decode this cycle never needs storage.
    assign wr_en   = qualify & fetch_ready_o & ~(bypass & decode_ready_i);
    assign rd_en   = stored_valid & decode_ready_i & ~redirect;
    assign valid_o = stored_valid | bypass;
    assign head    = bypass ? in_b : rd_b;
    assign pc_o    = valid_o ? head.pc : '0;
    assign in_b.pc = pc_i;

    // Lane 0 sits in the MSBs of the flat bus; lanes above WIDTH are tied off.
    for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
        if (g < WIDTH) begin : g_used
            assign in_b.inst[g] = idata_i[XLEN*(WIDTH-g)-1 -: XLEN];
            assign in_b.pred[g] = pred_i[g];
            assign in_b.mask[g] = lane_mask_i[g];
            assign inst_o[XLEN*(WIDTH-g)-1 -: XLEN] =
                (valid_o & head.mask[g]) ? head.inst[g] : NOP_INST;
            assign pred_o[g] = valid_o & head.mask[g] & head.pred[g];
        end else begin : g_spare
            logic lane_unused;
            assign in_b.inst[g] = NOP_INST;
            assign in_b.pred[g] = 1'b0;
            assign in_b.mask[g] = 1'b0;
            assign lane_unused  = ^{head.inst[g], head.pred[g], head.mask[g]};
        end
    end

    fetch2_bundle_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clock_i),
        .rst_n  (reset_ni),
        .flush  (redirect),
        .wr_en  (wr_en),
        .wr_data(in_b),
        .rd_en  (rd_en),
        .rd_data(rd_b),
        .count  (count_o)
    );

endmodule

// File: tb/tb_fetch2_buf.sv
// tb/tb_fetch2_buf.sv - directed and randomized checks of fetch2_buf against a queue model
module tb_fetch2_buf;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int SH = 2;

    logic          clock_i;
    logic          reset_ni;
    logic          fetch_valid_i;
    logic [32*W-1:0] idata_i;
    logic [W-1:0]  lane_mask_i;
    logic [W-1:0]  pred_i;
    logic [31:0]   pc_i;
    logic          branch_mispred_i;
    logic          wasnt_branch_i;
    logic          decode_ready_i;
    logic          fetch_ready_o;
    logic          valid_o;
    logic [32*W-1:0] inst_o;
    logic [W-1:0]  pred_o;
    logic [31:0]   pc_o;
    logic [2:0]    count_o;
    logic          branch_flush_o;

    fetch2_buf #(.WIDTH(W), .DEPTH(D), .FLUSH_SHADOW(SH)) dut (
        .clock_i         (clock_i),
        .reset_ni        (reset_ni),
        .fetch_valid_i   (fetch_valid_i),
        .idata_i         (idata_i),
        .lane_mask_i     (lane_mask_i),
        .pred_i          (pred_i),
        .pc_i            (pc_i),
        .branch_mispred_i(branch_mispred_i),
        .wasnt_branch_i  (wasnt_branch_i),
        .decode_ready_i  (decode_ready_i),
        .fetch_ready_o   (fetch_ready_o),
        .valid_o         (valid_o),
        .inst_o          (inst_o),
        .pred_o          (pred_o),
        .pc_o            (pc_o),
        .count_o         (count_o),
        .branch_flush_o  (branch_flush_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [32*W-1:0] inst;
        logic [W-1:0]    pred;
        logic [W-1:0]    mask;
        logic [31:0]     pc;
    } mb_t;

    mb_t q[$];
    int  shadow;
    int  checks;
    int  errors;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [32*W-1:0] d, input logic [W-1:0] m,
                         input logic [W-1:0] p, input logic [31:0] pc,
                         input logic mp, input logic wb, input logic dr);
        fetch_valid_i    = fv;
        idata_i          = d;
        lane_mask_i      = m;
        pred_i           = p;
        pc_i             = pc;
        branch_mispred_i = mp;
        wasnt_branch_i   = wb;
        decode_ready_i   = dr;
    endtask

    task automatic step(input string tag);
        logic            redirect;
        logic            flush;
        logic            qual;
        logic            byp;
        logic            e_valid;
        logic            deq;
        logic            enq;
        logic [32*W-1:0] e_inst;
        logic [W-1:0]    e_pred;
        logic [31:0]     e_pc;
        mb_t             head;
        mb_t             nb;
        #1;
        redirect = branch_mispred_i | wasnt_branch_i;
        flush    = redirect || (shadow > 0);
        qual     = fetch_valid_i && !flush && (lane_mask_i != '0);
        byp      = 1'b0;
`ifdef FETCH2_BUF_BYPASS_EN
        byp      = qual && (q.size() == 0);
`endif
        nb.inst = idata_i; nb.pred = pred_i; nb.mask = lane_mask_i; nb.pc = pc_i;
        e_valid = (q.size() > 0) || byp;
        head    = (q.size() > 0) ? q[0] : nb;
        e_inst  = '0;
        e_pred  = '0;
        e_pc    = '0;
        if (e_valid) begin
            e_pc   = head.pc;
            e_pred = head.pred & head.mask;
            for (int i = 0; i < W; i++)
                if (head.mask[i]) e_inst[32*(W-1-i) +: 32] = head.inst[32*(W-1-i) +: 32];
        end
        chk({tag, ".valid"}, valid_o, e_valid);
        chk({tag, ".inst"},  inst_o, e_inst);
        chk({tag, ".pred"},  pred_o, e_pred);
        chk({tag, ".pc"},    pc_o, e_pc);
        chk({tag, ".count"}, count_o, q.size());
        chk({tag, ".ready"}, fetch_ready_o, q.size() < D);
        chk({tag, ".flush"}, branch_flush_o, flush);
        @(posedge clock_i);
        if (redirect) begin
            q.delete();
            shadow = SH;
        end else begin
            deq = (q.size() > 0) && decode_ready_i;
            enq = qual && (q.size() < D) && !(byp && decode_ready_i);
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(nb);
            if (fetch_valid_i && shadow > 0) shadow--;
        end
        @(negedge clock_i);
    endtask

    task automatic idle(input logic dr);
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, dr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        shadow = 0;
        reset_ni = 1'b0;
        idle(1'b0);
        @(negedge clock_i);
        @(negedge clock_i);
        #1;
        chk("reset.valid", valid_o, 1'b0);
        chk("reset.inst",  inst_o, '0);
        chk("reset.pc",    pc_o, '0);
        chk("reset.ready", fetch_ready_o, 1'b1);
        chk("reset.flush", branch_flush_o, 1'b0);
        reset_ni = 1'b1;
        @(negedge clock_i);

        // Fill past capacity with decode stalled
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'($urandom), 32'h100 + 32'(4*k), 1'b0, 1'b0, 1'b0);
            step("fill");
        end
        idle(1'b0);
        #1;
        chk("fill.count", count_o, 3'd4);
        chk("fill.ready", fetch_ready_o, 1'b0);
        chk("fill.head_pc", pc_o, 32'h100);
        for (int k = 0; k < 5; k++) begin idle(1'b1); step("drain"); end

        // Lane masking and all-zero mask drop
        drive(1'b1, 64'h00000013_00100093, 2'b01, 2'b11, 32'h200, 1'b0, 1'b0, 1'b0);
        step("mask01");
        idle(1'b0);
        #1;
        chk("mask01.inst", inst_o, 64'h00000013_00000000);
        chk("mask01.pred", pred_o, 2'b01);
        idle(1'b1); step("mask_drain");
        drive(1'b1, 64'h00000013_00100093, 2'b00, 2'b11, 32'h204, 1'b0, 1'b0, 1'b0);
        step("mask00");
        idle(1'b0);
        #1;
        chk("mask00.count", count_o, 3'd0);

        // Mispredict with queue at 3 and a same-cycle enqueue
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'b00, 32'h300 + 32'(4*k), 1'b0, 1'b0, 1'b0);
            step("pre_redirect");
        end
        drive(1'b1, {$urandom, $urandom}, 2'b11, 2'b00, 32'h30c, 1'b1, 1'b0, 1'b0);
        step("redirect");
        #1;
        chk("redirect.count", count_o, 3'd0);
        chk("redirect.flush", branch_flush_o, 1'b1);
        for (int k = 0; k < SH + 1; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'b00, 32'h400 + 32'(4*k), 1'b0, 1'b0, 1'b0);
            step("shadow");
        end

        // Shadow held while the frontend stalls
        for (int k = 0; k < 3; k++) begin idle(1'b1); step("settle"); end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        step("wasnt_branch");
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            step("hold");
            #1;
            chk("hold.flush", branch_flush_o, 1'b1);
        end
        for (int k = 0; k < SH; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'b00, 32'h500, 1'b0, 1'b0, 1'b0);
            step("hold_release");
        end
        idle(1'b0);
        #1;
        chk("hold.released", branch_flush_o, 1'b0);

        // Simultaneous enqueue and dequeue across pointer wrap
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'($urandom), 32'h600 + 32'(4*k), 1'b0, 1'b0, 1'b0);
            step("simul_pre");
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'($urandom_range(1, 3)), 2'($urandom),
                  32'h700 + 32'(4*k), 1'b0, 1'b0, 1'b1);
            step("simul");
        end
        idle(1'b0);
        #1;
        chk("simul.count", count_o, 3'd2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom}, 2'($urandom), 2'($urandom), $urandom,
                  ($urandom % 16) == 0, ($urandom % 32) == 0, ($urandom % 3) != 0);
            step("rand");
        end

        // Asynchronous reset mid-queue
        for (int k = 0; k < SH + 1; k++) begin
            drive(1'b1, '0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
            step("pre_reset_clear");
        end
        for (int k = 0; k < 5; k++) begin idle(1'b1); step("pre_reset_drain"); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, {$urandom, $urandom}, 2'b11, 2'b11, 32'h800 + 32'(4*k), 1'b0, 1'b0, 1'b0);
            step("pre_reset_fill");
        end
        idle(1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst_q.valid", valid_o, 1'b0);
        chk("rst_q.inst",  inst_o, '0);
        chk("rst_q.pred",  pred_o, '0);
        chk("rst_q.pc",    pc_o, '0);
        chk("rst_q.count", count_o, '0);
        chk("rst_q.ready", fetch_ready_o, 1'b1);
        q.delete();
        shadow = 0;
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(negedge clock_i);

        // Asynchronous reset mid-shadow
        drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        step("pre_reset_redirect");
        idle(1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst_sh.flush", branch_flush_o, 1'b0);
        shadow = 0;
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(negedge clock_i);
        drive(1'b1, {$urandom, $urandom}, 2'b10, 2'b10, 32'h900, 1'b0, 1'b0, 1'b0);
        step("post_reset");
        idle(1'b0);
        step("post_reset_check");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch2_buf.md
FETCH2_BUF -- requirements
Module: fetch2_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 2, fetch lanes per bundle (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, bundle queue entries (power of two, >=2).
REQ-003 SHALL have parameter FLUSH_SHADOW, default 1, post-redirect discard cycles (0..7).
REQ-004 SHALL have ports:
  clock_i  in  1  single clock, rising edge.
  reset_ni  in  1  asynchronous active-low reset.
  fetch_valid_i  in  1  fetch bundle present; also the frontend advance strobe.
  idata_i  in  32*WIDTH  instructions; lane 0 in the MSBs.
  lane_mask_i  in  WIDTH  per-lane valid; bit 0 = lane 0.
  pred_i  in  WIDTH  per-lane taken prediction.
  pc_i  in  32  PC of lane 0.
  branch_mispred_i  in  1  backend redirect.
  wasnt_branch_i  in  1  predicted-taken non-branch redirect.
  decode_ready_i  in  1  decode accepts the head bundle.
  fetch_ready_o  out  1  queue can accept a bundle.
  valid_o  out  1  head bundle valid.
  inst_o  out  32*WIDTH  head instructions; masked lanes are zero.
  pred_o  out  WIDTH  head predictions; masked lanes are zero.
  pc_o  out  32  head PC.
  count_o  out  clog2(DEPTH)+1  occupancy.
  branch_flush_o  out  1  frontend flush request.

Function
REQ-005 SHALL define redirect = branch_mispred_i | wasnt_branch_i.
REQ-006 SHALL drive branch_flush_o = redirect | (shadow_cnt != 0), combinationally.
REQ-007 SHALL, on redirect, empty the queue at the next edge and load shadow_cnt with FLUSH_SHADOW; a same-cycle enqueue SHALL be discarded.
REQ-008 SHALL decrement shadow_cnt only at edges with fetch_valid_i=1 and no redirect; a stalled frontend holds the shadow.
REQ-009 SHALL discard every bundle arriving while branch_flush_o=1.
REQ-010 SHALL enqueue when fetch_valid_i & fetch_ready_o & ~branch_flush_o & (lane_mask_i != 0); an all-zero mask SHALL be dropped.
REQ-011 SHALL drive fetch_ready_o = (count_o < DEPTH); a full queue SHALL NOT accept, even if a dequeue occurs the same cycle.
REQ-012 SHALL present the head show-ahead: valid_o = (count_o != 0); dequeue when valid_o & decode_ready_i & ~redirect.
REQ-013 SHALL keep count_o unchanged on a simultaneous enqueue and dequeue.
REQ-014 SHALL wrap read and write pointers modulo DEPTH.
REQ-015 SHALL zero inst_o and pred_o lanes whose stored mask bit is 0, at the output.
REQ-016 SHALL have a minimum enqueue-to-valid_o latency of 1 cycle (without bypass).

Reset
REQ-017 SHALL, while reset_ni=0, asynchronously clear the pointers, count_o and shadow_cnt.
REQ-018 SHALL therefore hold valid_o=0, inst_o=0, pred_o=0, pc_o=0, branch_flush_o=0 (no redirect input asserted) and fetch_ready_o=1 during reset.
REQ-019 SHALL, when reset is asserted mid-shadow or mid-queue, lose all contents; no state survives.

Configuration
REQ-020 SHALL, with FETCH2_BUF_BYPASS_EN defined, forward a qualifying bundle to the outputs in the same cycle when the queue is empty. The bundle SHALL NOT be written when decode_ready_i=1 and SHALL be enqueued otherwise. This gives 0-cycle latency.
REQ-021 SHALL, without FETCH2_BUF_BYPASS_EN, always route through storage (REQ-016); interface identical.

Structure
REQ-022 SHALL take XLEN, NOP_INST (32'h0) and the bundle struct typedef (inst, pred, mask, pc) from shared package fetch_pkg.
REQ-023 SHALL instantiate one sub-module, fetch2_bundle_fifo (storage + pointers + count); flush/shadow control stays in fetch2_buf.

Verification
REQ-024 Fill: WIDTH=2, DEPTH=4, decode_ready_i=0, 5 bundles with pc 0x100..0x110 -> count_o=4, fetch_ready_o=0 after the 4th, 5th not stored, head pc_o=0x100.
REQ-025 Lane mask: idata_i=0x00000013_00100093, lane_mask_i=2'b01 -> inst_o=0x00000013_00000000; mask 2'b00 -> nothing enqueued.
REQ-026 Redirect: queue count 3, branch_mispred_i pulse with fetch_valid_i=1 -> next cycle count_o=0, branch_flush_o=1 for exactly 1 further fetch_valid_i cycle (FLUSH_SHADOW=1), bundles in that window dropped.
REQ-027 Shadow hold: FLUSH_SHADOW=2, redirect then fetch_valid_i=0 for 3 cycles -> branch_flush_o stays 1 until two fetch_valid_i cycles elapse.
REQ-028 Simultaneous: count 2, enqueue + dequeue for 10 cycles -> count_o stays 2, FIFO order preserved across pointer wrap.
REQ-029 Reset mid-operation: reset_ni low while count 3 and shadow 1 -> all outputs zero, fetch_ready_o=1 immediately, without waiting for a clock edge.
